// File: rtl/ahb_slave_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// AHB_package
// Shared AHB types for the per-slave port arbiter: transfer and burst
// encodings, arbitration mode, FSM state, and the burst-length decode used
// to size each grant.
// ---------------------------------------------------------------------------
package AHB_package;

  localparam int BEAT_CNT_W = 5;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_type;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  // Beats a grant lasts for a given burst type. Undefined-length INCR is
  // capped at incr_limit, which must fit the 5-bit beat counter.
  function automatic logic [BEAT_CNT_W-1:0] burst_beats(input hburst_type burst,
                                                        input int         incr_limit);
    logic [BEAT_CNT_W-1:0] beats;
    case (burst)
      HB_SINGLE:            beats = BEAT_CNT_W'(1);
      HB_INCR:              beats = BEAT_CNT_W'(incr_limit);
      HB_WRAP4,  HB_INCR4:  beats = BEAT_CNT_W'(4);
      HB_WRAP8,  HB_INCR8:  beats = BEAT_CNT_W'(8);
      HB_WRAP16, HB_INCR16: beats = BEAT_CNT_W'(16);
      default:              beats = BEAT_CNT_W'(1);
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_slave_port_arbiter_rotate_pick.sv
// ---------------------------------------------------------------------------
// ahb_rotate_pick
// Combinational rotating-priority picker: returns the first set bit of req
// found when searching upward from start_idx and wrapping at N.
//   req       [N-1:0]     request vector
//   start_idx [IDX_W-1:0] index searched first (must be < N)
//   onehot    [N-1:0]     one-hot winner, all zero when req is zero
// ---------------------------------------------------------------------------
module ahb_rotate_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start_idx,
  output logic [N-1:0]     onehot
);

  logic [N-1:0] req_rot;
  logic [N-1:0] pick_rot;

  // Rotate so start_idx lands on bit 0, isolate the lowest set bit with the
  // two's-complement trick, then rotate the winner back into place.
  always_comb begin
    req_rot  = N'({req, req} >> start_idx);
    pick_rot = req_rot & (~req_rot + N'(1));
    onehot   = N'(({pick_rot, pick_rot} << start_idx) >> N);
  end

endmodule

// File: rtl/ahb_slave_port_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_slave_port_arbiter
// Burst-aware arbiter for one AHB slave port. Grants one of MASTER_NUM
// masters, holds the grant for the beats encoded in the owner's hburst,
// and hands over to the next winner in the same cycle the last beat is
// accepted. Fixed-priority or round-robin selection via ARB_MODE.
//   hclk, hreset     clock, asynchronous active-high reset
//   hreq   [M]       per-master request for this slave
//   hburst [M]       per-master burst type
//   htrans [M]       per-master transfer type
//   hwait            slave wait; freezes all arbitration state
//   hgrant [M]       registered one-hot grant
//   hsel             slave select (any grant)
//   hmaster_id       binary owner index, 0 when idle
//   hlast            owner's final beat is on the bus
// ---------------------------------------------------------------------------
module ahb_slave_port_arbiter
  import AHB_package::*;
#(
  parameter int        MASTER_NUM = 4,
  parameter arb_mode_e ARB_MODE   = ARB_RR,
  parameter int        INCR_LIMIT = 16,
  parameter int        ID_W       = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [MASTER_NUM-1:0] hreq,
  input  hburst_type            hburst [MASTER_NUM],
  input  htrans_type            htrans [MASTER_NUM],
  input  logic                  hwait,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic                  hsel,
  output logic [ID_W-1:0]       hmaster_id,
  output logic                  hlast
);

  arb_state_e             state_q,  state_d;
  logic [MASTER_NUM-1:0]  grant_q,  grant_d;
  logic [BEAT_CNT_W-1:0]  count_q,  count_d;
  hburst_type             burst_q,  burst_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;

  logic [ID_W-1:0]       owner_idx;
  logic                  owner_req;
  htrans_type            owner_trans;
  hburst_type            owner_burst;
  hburst_type            burst_eff;
  logic [BEAT_CNT_W-1:0] limit;
  logic                  owned, active, first_beat, undef_len;
  logic                  last_beat, beat_ok, release_ok;
  logic [ID_W-1:0]       search_base, start_idx;
  logic [MASTER_NUM-1:0] winner;

  // Owner's request-side signals, selected by the one-hot grant.
  always_comb begin
    owner_idx   = '0;
    owner_req   = 1'b0;
    owner_trans = HT_IDLE;
    owner_burst = HB_SINGLE;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (grant_q[i]) begin
        owner_idx   = ID_W'(i);
        owner_req   = hreq[i];
        owner_trans = htrans[i];
        owner_burst = hburst[i];
      end
    end
  end

  // Before the first beat is accepted the burst type is not latched yet, so
  // the owner's live hburst sizes the grant (needed for SINGLE's hlast).
  always_comb begin
    owned      = (state_q == ST_OWNED);
    first_beat = (count_q == '0);
    burst_eff  = first_beat ? owner_burst : burst_q;
    limit      = burst_beats(burst_eff, INCR_LIMIT);
    active     = owner_trans inside {HT_NONSEQ, HT_SEQ};
    undef_len  = burst_eff inside {HB_SINGLE, HB_INCR};
    last_beat  = owned && active && (count_q == limit - BEAT_CNT_W'(1));
    beat_ok    = owned && active && !hwait;
    release_ok = (beat_ok && last_beat) ||
                 (owned && undef_len && !hwait &&
                  (!owner_req || owner_trans == HT_IDLE));
  end

  // At a release the releasing owner is the most recent owner, so the
  // search starts after it even though rr_ptr_q only updates on this edge.
  always_comb begin
    search_base = owned ? owner_idx : rr_ptr_q;
    if (ARB_MODE == ARB_FIXED) begin
      start_idx = '0;
    end else if (search_base == ID_W'(MASTER_NUM - 1)) begin
      start_idx = '0;
    end else begin
      start_idx = search_base + ID_W'(1);
    end
  end

  ahb_rotate_pick #(
    .N     (MASTER_NUM),
    .IDX_W (ID_W)
  ) u_pick (
    .req       (hreq),
    .start_idx (start_idx),
    .onehot    (winner)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    count_d  = count_q;
    burst_d  = burst_q;
    rr_ptr_d = rr_ptr_q;
    if (!hwait) begin
      case (state_q)
        ST_IDLE: begin
          if (|hreq) begin
            state_d = ST_OWNED;
            grant_d = winner;
            count_d = '0;
          end
        end
        ST_OWNED: begin
          if (beat_ok) begin
            if (count_q != limit) count_d = count_q + BEAT_CNT_W'(1);
            if (first_beat && owner_trans == HT_NONSEQ) burst_d = owner_burst;
          end
          if (release_ok) begin
            rr_ptr_d = owner_idx;
            count_d  = '0;
            grant_d  = winner;
            state_d  = (|hreq) ? ST_OWNED : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      count_q  <= '0;
      burst_q  <= HB_SINGLE;
      rr_ptr_q <= ID_W'(MASTER_NUM - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      count_q  <= count_d;
      burst_q  <= burst_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign hgrant     = grant_q;
  assign hsel       = |grant_q;
  assign hmaster_id = owner_idx;
  assign hlast      = last_beat;

endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_port_arbiter
// Directed bench for the slave-port arbiter. Two instances share stimulus:
// dut_rr (round-robin, INCR_LIMIT=4) and dut_fx (fixed priority, held in
// reset except during the priority comparison). Each stimulus cycle queues
// the hand-derived grant/hlast for that cycle; per-DUT monitors sample on
// the falling edge and compare against the queue, expecting an idle port
// in any cycle without a queued entry.
// ---------------------------------------------------------------------------
module tb_ahb_slave_port_arbiter;
  import AHB_package::*;

  logic       hclk = 1'b0;
  logic       hreset, hreset_fx, hwait;
  logic [3:0] hreq;
  hburst_type hburst [4];
  htrans_type htrans [4];

  logic [3:0] rr_grant, fx_grant;
  logic       rr_hsel, fx_hsel, rr_last, fx_last;
  logic [1:0] rr_id, fx_id;

  typedef struct {
    int         at;
    logic [3:0] grant;
    logic       last;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fx[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  ahb_slave_port_arbiter #(
    .MASTER_NUM (4), .ARB_MODE (ARB_RR), .INCR_LIMIT (4)
  ) dut_rr (
    .hclk (hclk), .hreset (hreset), .hreq (hreq), .hburst (hburst),
    .htrans (htrans), .hwait (hwait), .hgrant (rr_grant), .hsel (rr_hsel),
    .hmaster_id (rr_id), .hlast (rr_last)
  );

  ahb_slave_port_arbiter #(
    .MASTER_NUM (4), .ARB_MODE (ARB_FIXED), .INCR_LIMIT (16)
  ) dut_fx (
    .hclk (hclk), .hreset (hreset_fx), .hreq (hreq), .hburst (hburst),
    .htrans (htrans), .hwait (hwait), .hgrant (fx_grant), .hsel (fx_hsel),
    .hmaster_id (fx_id), .hlast (fx_last)
  );

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Monitors: {grant, hsel, id, hlast} against the entry queued for this cycle.
  always @(negedge hclk) begin : mon_rr
    exp_t e;
    e = '{at: cyc, grant: 4'b0000, last: 1'b0};
    if (q_rr.size() > 0 && q_rr[0].at == cyc) e = q_rr.pop_front();
    check("rr_port", {rr_grant, rr_hsel, rr_id, rr_last},
          {e.grant, |e.grant, idx_of(e.grant), e.last});
  end

  always @(negedge hclk) begin : mon_fx
    exp_t e;
    e = '{at: cyc, grant: 4'b0000, last: 1'b0};
    if (q_fx.size() > 0 && q_fx[0].at == cyc) e = q_fx.pop_front();
    check("fx_port", {fx_grant, fx_hsel, fx_id, fx_last},
          {e.grant, |e.grant, idx_of(e.grant), e.last});
  end

  // Queue this cycle's expectations, then advance to 1 time unit past the
  // next rising edge where the following cycle's inputs are driven.
  task automatic step2(input logic [3:0] g, input logic l,
                       input logic [3:0] gf, input logic lf);
    if (g != 4'b0000)  q_rr.push_back('{at: cyc, grant: g,  last: l});
    if (gf != 4'b0000) q_fx.push_back('{at: cyc, grant: gf, last: lf});
    @(posedge hclk);
    #1;
  endtask

  task automatic step(input logic [3:0] g, input logic l);
    step2(g, l, 4'b0000, 1'b0);
  endtask

  // NOTE: stimulus is driven with blocking assignments just after the
  // rising edge, well clear of the edge the DUT samples on.
  task automatic idle_all();
    hreq  = 4'b0000;
    hwait = 1'b0;
    for (int i = 0; i < 4; i++) begin
      htrans[i] = HT_IDLE;
      hburst[i] = HB_SINGLE;
    end
  endtask

  initial begin
    hreset    = 1'b1;
    hreset_fx = 1'b1;
    idle_all();
    #1;
    check("reset_rr", {rr_grant, rr_hsel, rr_id, rr_last}, 8'h00);
    check("reset_fx", {fx_grant, fx_hsel, fx_id, fx_last}, 8'h00);
    @(posedge hclk);
    #1;
    step(4'b0000, 1'b0);
    hreset = 1'b0;
    step(4'b0000, 1'b0);

    // SINGLE from master 2: grant next cycle, hlast on the NONSEQ, back to idle.
    hreq = 4'b0100; htrans[2] = HT_NONSEQ;
    step(4'b0000, 1'b0);
    hreq = 4'b0000;
    step(4'b0100, 1'b1);
    idle_all();
    step(4'b0000, 1'b0);

    // INCR4 from master 1 with a 3-cycle wait on beat 2; master 3 waiting.
    hreq = 4'b0010; hburst[1] = HB_INCR4; htrans[1] = HT_NONSEQ;
    step(4'b0000, 1'b0);
    hreq = 4'b1010; htrans[3] = HT_NONSEQ;
    step(4'b0010, 1'b0);
    htrans[1] = HT_SEQ; hwait = 1'b1;
    repeat (3) step(4'b0010, 1'b0);
    hwait = 1'b0;
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b1);
    hreq = 4'b0000; htrans[1] = HT_IDLE;
    step(4'b1000, 1'b1);
    idle_all();
    step(4'b0000, 1'b0);

    // All four request SINGLE: RR rotates 0,1,2,3,0; fixed keeps master 0.
    for (int i = 0; i < 4; i++) htrans[i] = HT_NONSEQ;
    hreq = 4'b1111; hreset_fx = 1'b0;
    step2(4'b0000, 1'b0, 4'b0000, 1'b0);
    step2(4'b0001, 1'b1, 4'b0001, 1'b1);
    step2(4'b0010, 1'b1, 4'b0001, 1'b1);
    step2(4'b0100, 1'b1, 4'b0001, 1'b1);
    step2(4'b1000, 1'b1, 4'b0001, 1'b1);
    hreq = 4'b0000;
    step2(4'b0001, 1'b1, 4'b0001, 1'b1);
    idle_all(); hreset_fx = 1'b1;
    step2(4'b0000, 1'b0, 4'b0000, 1'b0);

    // INCR capped at 4 beats with master 1 requesting on; master 2 then wins.
    hreq = 4'b0110; hburst[1] = HB_INCR; htrans[1] = HT_NONSEQ; htrans[2] = HT_NONSEQ;
    step(4'b0000, 1'b0);
    step(4'b0010, 1'b0);
    htrans[1] = HT_SEQ;
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b1);
    hreq = 4'b0000; htrans[1] = HT_IDLE;
    step(4'b0100, 1'b1);
    idle_all();
    step(4'b0000, 1'b0);

    // WRAP8 from master 0, request dropped after beat 1, one BUSY inserted.
    hreq = 4'b0001; hburst[0] = HB_WRAP8; htrans[0] = HT_NONSEQ;
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    hreq = 4'b0000; htrans[0] = HT_SEQ;
    step(4'b0001, 1'b0);
    htrans[0] = HT_BUSY;
    step(4'b0001, 1'b0);
    htrans[0] = HT_SEQ;
    repeat (5) step(4'b0001, 1'b0);
    step(4'b0001, 1'b1);
    idle_all();
    step(4'b0000, 1'b0);

    // INCR from master 3 dropped mid-burst while master 2 requests that cycle.
    hreq = 4'b1000; hburst[3] = HB_INCR; htrans[3] = HT_NONSEQ;
    step(4'b0000, 1'b0);
    step(4'b1000, 1'b0);
    htrans[3] = HT_SEQ;
    step(4'b1000, 1'b0);
    hreq = 4'b0100; htrans[3] = HT_IDLE; htrans[2] = HT_NONSEQ;
    step(4'b1000, 1'b0);
    hreq = 4'b0000;
    step(4'b0100, 1'b1);
    idle_all();
    step(4'b0000, 1'b0);

    // INCR16 from master 0, reset pulsed during beat 3, request left pending.
    hreq = 4'b0001; hburst[0] = HB_INCR16; htrans[0] = HT_NONSEQ;
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);
    htrans[0] = HT_SEQ;
    step(4'b0001, 1'b0);
    #1;
    check("pre_reset", {rr_grant, rr_hsel}, {4'b0001, 1'b1});
    hreset = 1'b1;
    #1;
    check("async_reset", {rr_grant, rr_hsel, rr_id, rr_last}, 8'h00);
    step(4'b0000, 1'b0);
    hburst[0] = HB_SINGLE; htrans[0] = HT_NONSEQ;
    step(4'b0000, 1'b0);
    hreset = 1'b0;
    step(4'b0000, 1'b0);
    hreq = 4'b0000;
    step(4'b0001, 1'b1);
    idle_all();
    step(4'b0000, 1'b0);

    check("leftover_rr", q_rr.size(), 0);
    check("leftover_fx", q_fx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_port_arbiter.md
# ahb_slave_port_arbiter

Parametrised per-slave AHB arbiter that resolves requests from `MASTER_NUM` masters for one slave port. It replaces the generated single-purpose per-slave arbiters with one module selectable between fixed-priority and round-robin modes. Grants are burst-aware: each grant is held for exactly the beats encoded in the owner's `hburst`, and a new owner is handed over with no idle cycle. It sits in the interconnect between the master-side request decode and the slave-side data/address mux, which it steers through `hmaster_id`.

## Interface
- `MASTER_NUM`, 4: number of requesting masters, range 1–16.
- `ARB_MODE`, `ARB_RR`: `ARB_FIXED` (master 0 highest priority) or `ARB_RR` (round-robin).
- `INCR_LIMIT`, 16: maximum beats granted to an undefined-length INCR burst before forced re-arbitration.
- `ID_W`, `$clog2(MASTER_NUM)` (minimum 1): width of `hmaster_id`.

Ports:
- `hclk` input 1: single clock, rising edge.
- `hreset` input 1: asynchronous, active-high reset.
- `hreq` input `MASTER_NUM`: per-master request for this slave.
- `hburst` input `MASTER_NUM` x `hburst_type`: per-master burst type.
- `htrans` input `MASTER_NUM` x `htrans_type`: per-master transfer type.
- `hwait` input 1: slave wait; high stalls the current beat.
- `hgrant` output `MASTER_NUM`: registered one-hot grant.
- `hsel` output 1: slave select, `|hgrant`.
- `hmaster_id` output `ID_W`: binary index of the owner; 0 when idle.
- `hlast` output 1: high while the owner's final beat is on the bus.

## Operation
- FSM has two states:
  - IDLE (no owner): if any `hreq` is set, pick a winner, register its grant, and go to OWNED.
  - OWNED: count accepted beats. A beat is accepted when the owner's `htrans` is NONSEQ or SEQ and `hwait`=0.
- Beat limit is latched from the owner's `hburst` on its first accepted NONSEQ:
  - SINGLE=1; INCR4/WRAP4=4; INCR8/WRAP8=8; INCR16/WRAP16=16; INCR=`INCR_LIMIT`.
  - The beat counter is 5 bits and saturates at the limit.
- `hlast` = OWNED & (count == limit−1) & owner `htrans` ∈ {NONSEQ, SEQ}.
- Release: on an accepted beat with `hlast`=1, or for INCR/SINGLE when the owner's `hreq`=0 or `htrans`=IDLE while `hwait`=0.
  - At release, re-arbitrate in the same cycle. Go to OWNED with the new winner, or to IDLE if there are no requests.
- Fixed-length bursts (4/8/16) are not interruptible. If the owner drops `hreq` mid-burst, the grant is held until the limit is reached.
- Priority selection:
  - `ARB_FIXED`: lowest requesting index wins.
  - `ARB_RR`: search starts at `(last_owner+1) mod MASTER_NUM`. The pointer updates only at release.
- BUSY beats do not count and do not release.
- `hwait`=1 freezes the counter, FSM, grant and pointer.
- `MASTER_NUM`=1: the arbiter degenerates to grant = `hreq`, with the same burst tracking.

## Timing
- Reset (async assert, sync deassert by the system): `hgrant`=0, `hsel`=0, `hmaster_id`=0, `hlast`=0, counter=0, RR pointer=`MASTER_NUM`−1 (so master 0 is searched first), state IDLE.
- Latency: `hreq` sampled high in cycle n while IDLE → `hgrant` high in cycle n+1.
- Handover: last beat accepted in cycle n → new owner's `hgrant` in n+1, with no dead cycle.
- Simultaneous new request and release in the same cycle: the new request takes part in that arbitration.
- Reset asserted mid-burst: all outputs clear immediately, without waiting for `hclk`.

## Structure
- `AHB_package` additions:
  - `arb_mode_e` {`ARB_FIXED`, `ARB_RR`}.
  - `arb_state_e` {IDLE, OWNED}.
  - function `burst_beats(hburst_type, incr_limit)` returning 5 bits.
  - `htrans_type` (if not already present).
- Sub-module `ahb_rotate_pick`: a combinational one-hot rotating-priority picker with inputs `req` and `start_idx` and output `onehot`. Fixed mode drives `start_idx`=0.
- The top level holds the FSM, beat counter, RR pointer, and one-hot to binary conversion for `hmaster_id`.

## Test plan
- Reset, then `hreq`=4'b0100 with SINGLE → `hgrant`=0100 and `hmaster_id`=2 one cycle later; `hlast`=1 on the NONSEQ beat; release to IDLE after that beat.
- Master 1 runs INCR4 with `hwait`=1 on beat 2 for 3 cycles, while master 3 requests → grant held; `hlast` on 4th accepted beat only; master 3 granted the next cycle with no gap.
- `ARB_RR`, all four masters request SINGLE continuously → grant order 0,1,2,3,0; `ARB_FIXED` same stimulus → master 0 every time.
- INCR with `INCR_LIMIT`=4 and the owner requesting forever alongside master 2 → forced release after 4 beats, then master 2 granted (RR).
- Owner drops `hreq` mid-WRAP8 → grant held for all 8 beats; owner drops `hreq` mid-INCR → released that cycle.
- `hreset` pulsed high at beat 3 of INCR16 → all outputs 0 asynchronously; after deassertion a pending `hreq`=0001 is granted to master 0.
